cellrv32_cpu_rf_wb_seq: RTL and testbench
=========================================

Name: cellrv32_cpu_rf_wb_seq

Overview:
Write-side sequencer for the CPU general purpose register file. It collects results from up to four producers (ALU, memory, CSR, next-PC), arbitrates them into a small result buffer, and drains them into the register file's single shared rd/rs1 port. That port serves both writes and rs1 reads, so the block decides each cycle whether the port writes or reads. After reset it also performs the mandatory x0 clearing write and reports RAW hazards against buffered results.

Parameters:
XLEN, 32, data path width
CPU_EXTENSION_RISCV_E, 0, 1 = 16-entry register file (RV32E), 0 = 32 entries
DEPTH, 4, result buffer entries (power of two, 2..16)

Ports:
clk_i  in  1  global clock, rising edge
rstn_i  in  1  global reset, asynchronous, active-low
src_valid_i  in  4  producer result valid; bit0 mem, bit1 csr, bit2 alu, bit3 npc
src_ready_o  out  4  producer result accepted this cycle
src_rd_i  in  4*5  destination register per producer (bits [5i+4:5i])
src_data_i  in  4*XLEN  write data per producer
rd_req_i  in  1  control unit wants the shared port for an rs1 read this cycle
rd_stall_o  out  1  shared port taken by a forced write; rs1 read denied
rs1_i  in  5  rs1 of the instruction in decode, for hazard check
rs2_i  in  5  rs2 of the instruction in decode, for hazard check
hazard_o  out  1  rs1_i or rs2_i (non-zero) matches a buffered rd
rf_we_o  out  1  register file write enable
rf_zero_we_o  out  1  forced write to x0
rf_rd_o  out  5  write address
rf_wdata_o  out  XLEN  write data
illegal_o  out  1  one-cycle pulse: RV32E result targeting x16..x31 (dropped)
busy_o  out  1  init running or buffer non-empty

Behaviour:
- Reset (rstn_i low, asynchronous): buffer empty, pointers 0, FSM=S_INIT. Outputs src_ready_o=0, rd_stall_o=0, hazard_o=0, rf_we_o=0, rf_zero_we_o=0, rf_rd_o=0, rf_wdata_o=0, illegal_o=0, busy_o=1.
- FSM S_INIT: for one cycle drive rf_zero_we_o=1, rf_we_o=1, rf_rd_o=0, rf_wdata_o=0; src_ready_o=0 and rd_stall_o=1 in this cycle. Then go to S_RUN.
- FSM S_RUN is the normal state. It is only left by reset; reset mid-operation discards all buffered entries.
- Arbitration: fixed priority mem > csr > alu > npc. At most one grant per cycle.
  - src_ready_o[i]=1 only for the granted source, and only when the buffer is not full or is dequeuing in the same cycle.
  - Ready is combinational from valid, ready may depend on valid, and a transfer occurs when valid & ready.
- Accepted results with rd=0 are consumed and not buffered.
- With RV32E, an accepted rd[4]=1 is consumed, not buffered, and pulses illegal_o in the next cycle.
- Drain: the buffer head is written when non-empty and either rd_req_i=0 or the buffer is full.
  - On a full-buffer forced write, rd_stall_o=1 that cycle.
  - rf_we_o/rf_rd_o/rf_wdata_o are registered: a write decided in cycle N appears on the outputs in cycle N+1 for exactly one cycle. Minimum accept-to-write latency is 2 cycles.
- Full/empty: full with no dequeue means no ready. A simultaneous enqueue and dequeue keeps the count. Pointers wrap modulo DEPTH.
- hazard_o is combinational: any valid entry, or the registered write in flight, with rd == rs1_i or rd == rs2_i, where that rs is non-zero.
- busy_o = (state==S_INIT) | (count!=0) | rf_we_o.

Optional Feature:
Macro CELLRV32_RF_CLEAR_ON_RESET_EN.
- Defined: S_INIT sweeps all register addresses 0..N-1 (N=16 or 32) writing 0, one per cycle. rf_zero_we_o=1 only for address 0. The block then enters S_RUN, so init lasts N cycles.
- Undefined: only x0 is cleared and init lasts one cycle.

Decomposition:
- Package cellrv32_package gets:
  - enum wb_state_t {S_INIT, S_RUN}
  - struct wb_entry_t {rd[4:0], data[XLEN-1:0]}
  - constants wb_src_mem_c=0, wb_src_csr_c=1, wb_src_alu_c=2, wb_src_npc_c=3
- One sub-module, cellrv32_cpu_rf_wb_fifo: synchronous FIFO with per-entry rd outputs for the hazard compare. The arbiter and FSM stay in the top.

Test Plan:
- Release reset, no stimulus -> cycle 1: rf_zero_we_o=1, rf_rd_o=0, rf_wdata_o=0. Then S_RUN and busy_o=0. With the macro defined, 32 consecutive writes to addresses 0..31.
- alu valid rd=5 data=0xDEADBEEF, rd_req_i=0 -> src_ready_o=4'b0100. Two cycles later rf_we_o=1, rf_rd_o=5, rf_wdata_o=0xDEADBEEF.
- mem (rd=3, 0x11) and alu (rd=4, 0x22) valid together -> mem granted first. Writes appear in order x3=0x11 then x4=0x22.
- rd_req_i held 1 while DEPTH=4 results arrive -> no writes while not full. On the 4th entry: forced write and rd_stall_o=1, and src_ready_o=0 until a dequeue.
- Buffered rd=7, rs1_i=7 -> hazard_o=1. With rs1_i=0 and rd=0 submitted -> consumed, hazard_o=0, no write.
- RV32E, csr rd=20 -> consumed, illegal_o pulses once, no write. Assert rstn_i mid-burst -> outputs reset at once and init repeats.

Source files
------------

// File: rtl/cellrv32_package.sv
// Shared types and constants for the register-file write-back sequencer.
package cellrv32_package;

  localparam int unsigned wb_xlen_c = 32;

  // Producer slots; a lower index wins arbitration.
  localparam int unsigned wb_src_mem_c = 0;
  localparam int unsigned wb_src_csr_c = 1;
  localparam int unsigned wb_src_alu_c = 2;
  localparam int unsigned wb_src_npc_c = 3;

  typedef enum logic {S_INIT, S_RUN} wb_state_t;

  typedef struct packed {
    logic [4:0]           rd;
    logic [wb_xlen_c-1:0] data;
  } wb_entry_t;

  // True when rd would be read by a non-zero rs1 or rs2.
  function automatic logic wb_rs_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return ((rs1 != 5'd0) && (rd == rs1)) || ((rs2 != 5'd0) && (rd == rs2));
  endfunction

endpackage

// File: rtl/cellrv32_cpu_rf_wb_fifo.sv
// Result buffer: synchronous FIFO that also exposes every entry's rd and
// valid bit so the top can check RAW hazards against buffered results.
module cellrv32_cpu_rf_wb_fifo #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               we_i,
  input  logic [4:0]         wrd_i,
  input  logic [XLEN-1:0]    wdata_i,
  input  logic               re_i,
  output logic [4:0]         rd_o,
  output logic [XLEN-1:0]    data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [DEPTH*5-1:0] ent_rd_o,
  output logic [DEPTH-1:0]   ent_vld_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q;
  logic [DEPTH-1:0] vld_q;
  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      if (re_i) begin
        rptr_q        <= rptr_q + AW'(1);
        vld_q[rptr_q] <= 1'b0;
      end
      if (we_i) begin
        wptr_q        <= wptr_q + AW'(1);
        vld_q[wptr_q] <= 1'b1;
      end
      case ({we_i, re_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      rd_q[wptr_q]   <= wrd_i;
      data_q[wptr_q] <= wdata_i;
    end
  end

  always_comb begin
    ent_rd_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_rd_o[5*i +: 5] = rd_q[i];
    end
  end

  assign rd_o      = rd_q[rptr_q];
  assign data_o    = data_q[rptr_q];
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign ent_vld_o = vld_q;

endmodule

// File: rtl/cellrv32_cpu_rf_wb_seq.sv
// Write-side sequencer for the GPR file: arbitrates producer results into a
// buffer and drains them onto the shared rd/rs1 port. Define
// CELLRV32_RF_CLEAR_ON_RESET_EN to sweep-clear all registers after reset.
module cellrv32_cpu_rf_wb_seq
  import cellrv32_package::*;
#(
  parameter int unsigned XLEN                  = 32,
  parameter int unsigned CPU_EXTENSION_RISCV_E = 0,
  parameter int unsigned DEPTH                 = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [3:0]        src_valid_i,
  output logic [3:0]        src_ready_o,
  input  logic [19:0]       src_rd_i,
  input  logic [4*XLEN-1:0] src_data_i,
  input  logic              rd_req_i,
  output logic              rd_stall_o,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  output logic              hazard_o,
  output logic              rf_we_o,
  output logic              rf_zero_we_o,
  output logic [4:0]        rf_rd_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic              illegal_o,
  output logic              busy_o
);

  localparam int unsigned NREG  = (CPU_EXTENSION_RISCV_E != 0) ? 16 : 32;
  localparam bit          RV32E = (CPU_EXTENSION_RISCV_E != 0);

  wb_state_t state_q, state_d;

  logic [4:0] init_addr;
  logic       init_last;

`ifdef CELLRV32_RF_CLEAR_ON_RESET_EN
  logic [4:0] init_addr_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      init_addr_q <= '0;
    end else if (state_q == S_INIT) begin
      init_addr_q <= init_addr_q + 5'd1;
    end
  end

  assign init_addr = init_addr_q;
  assign init_last = (init_addr_q == 5'(NREG - 1));
`else
  assign init_addr = '0;
  assign init_last = 1'b1;
`endif

  logic              fifo_we, deq;
  logic [4:0]        head_rd;
  logic [XLEN-1:0]   head_data;
  logic              fifo_full, fifo_empty;
  logic [DEPTH*5-1:0] ent_rd;
  logic [DEPTH-1:0]  ent_vld;
  logic [3:0]        grant;
  logic              found;
  logic [4:0]        acc_rd;
  logic [XLEN-1:0]   acc_data;

  logic              dec_we, dec_zero, dec_stall, dec_ill;
  logic [4:0]        dec_rd;
  logic [XLEN-1:0]   dec_data;

  cellrv32_cpu_rf_wb_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .we_i      (fifo_we),
    .wrd_i     (acc_rd),
    .wdata_i   (acc_data),
    .re_i      (deq),
    .rd_o      (head_rd),
    .data_o    (head_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .ent_rd_o  (ent_rd),
    .ent_vld_o (ent_vld)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (init_last) state_d = S_RUN;
      default: state_d = state_q;
    endcase
  end

  // Grant, enqueue/drain decisions and the next value of the write port.
  always_comb begin
    src_ready_o = '0;
    fifo_we     = 1'b0;
    deq         = 1'b0;
    grant       = '0;
    found       = 1'b0;
    acc_rd      = '0;
    acc_data    = '0;
    dec_we      = 1'b0;
    dec_zero    = 1'b0;
    dec_stall   = 1'b0;
    dec_ill     = 1'b0;
    dec_rd      = '0;
    dec_data    = '0;

    for (int i = int'(wb_src_mem_c); i <= int'(wb_src_npc_c); i++) begin
      if (!found && src_valid_i[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        acc_rd   = src_rd_i[5*i +: 5];
        acc_data = src_data_i[XLEN*i +: XLEN];
      end
    end

    case (state_q)
      S_INIT: begin
        dec_we    = 1'b1;
        dec_zero  = (init_addr == 5'd0);
        dec_rd    = init_addr;
        dec_stall = 1'b1;
      end
      S_RUN: begin
        deq = !fifo_empty && (!rd_req_i || fifo_full);
        if (deq) begin
          dec_we    = 1'b1;
          dec_rd    = head_rd;
          dec_data  = head_data;
          dec_stall = rd_req_i;
        end
        if (!fifo_full || deq) begin
          src_ready_o = grant;
          fifo_we     = found && (acc_rd != 5'd0) && !(RV32E && acc_rd[4]);
          dec_ill     = found && RV32E && acc_rd[4];
        end
      end
      default: begin
        dec_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rf_we_o      <= 1'b0;
      rf_zero_we_o <= 1'b0;
      rf_rd_o      <= '0;
      rf_wdata_o   <= '0;
      rd_stall_o   <= 1'b0;
      illegal_o    <= 1'b0;
    end else begin
      rf_we_o      <= dec_we;
      rf_zero_we_o <= dec_zero;
      rf_rd_o      <= dec_rd;
      rf_wdata_o   <= dec_data;
      rd_stall_o   <= dec_stall;
      illegal_o    <= dec_ill;
    end
  end

  // RAW check covers buffered entries plus the write currently on the port.
  always_comb begin
    hazard_o = rf_we_o && wb_rs_hit(rf_rd_o, rs1_i, rs2_i);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_vld[i] && wb_rs_hit(ent_rd[5*i +: 5], rs1_i, rs2_i)) begin
        hazard_o = 1'b1;
      end
    end
  end

  assign busy_o = (state_q == S_INIT) || !fifo_empty || rf_we_o;

endmodule

// File: tb/tb_cellrv32_cpu_rf_wb_seq.sv
// Bench: an RV32I and an RV32E instance run against a queue-based reference model.
`timescale 1ns/1ps
module tb_cellrv32_cpu_rf_wb_seq;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
`ifdef CELLRV32_RF_CLEAR_ON_RESET_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [3:0]        src_valid [2];
  logic [19:0]       src_rd    [2];
  logic [4*XLEN-1:0] src_data  [2];
  logic              rd_req;
  logic [4:0]        rs1, rs2;
  logic [3:0]        src_ready [2];
  logic              rd_stall [2], hazard [2], rf_we [2], rf_zero_we [2], illegal [2], busy [2];
  logic [4:0]        rf_rd [2];
  logic [XLEN-1:0]   rf_wdata [2];

  cellrv32_cpu_rf_wb_seq #(.XLEN(XLEN), .CPU_EXTENSION_RISCV_E(0), .DEPTH(DEPTH)) dut_i (
    .clk_i(clk), .rstn_i(rstn), .src_valid_i(src_valid[0]), .src_ready_o(src_ready[0]),
    .src_rd_i(src_rd[0]), .src_data_i(src_data[0]), .rd_req_i(rd_req), .rd_stall_o(rd_stall[0]),
    .rs1_i(rs1), .rs2_i(rs2), .hazard_o(hazard[0]), .rf_we_o(rf_we[0]),
    .rf_zero_we_o(rf_zero_we[0]), .rf_rd_o(rf_rd[0]), .rf_wdata_o(rf_wdata[0]),
    .illegal_o(illegal[0]), .busy_o(busy[0]));

  cellrv32_cpu_rf_wb_seq #(.XLEN(XLEN), .CPU_EXTENSION_RISCV_E(1), .DEPTH(DEPTH)) dut_e (
    .clk_i(clk), .rstn_i(rstn), .src_valid_i(src_valid[1]), .src_ready_o(src_ready[1]),
    .src_rd_i(src_rd[1]), .src_data_i(src_data[1]), .rd_req_i(rd_req), .rd_stall_o(rd_stall[1]),
    .rs1_i(rs1), .rs2_i(rs2), .hazard_o(hazard[1]), .rf_we_o(rf_we[1]),
    .rf_zero_we_o(rf_zero_we[1]), .rf_rd_o(rf_rd[1]), .rf_wdata_o(rf_wdata[1]),
    .illegal_o(illegal[1]), .busy_o(busy[1]));

  int total, bad;

  // Producer-side pending results, per instance.
  logic [3:0]      pv   [2];
  logic [4:0]      prd  [2][4];
  logic [XLEN-1:0] pdat [2][4];

  // Reference model: buffered results in arrival order and the expected port.
  int              mq_n   [2];
  logic [4:0]      mq_rd  [2][DEPTH];
  logic [XLEN-1:0] mq_dat [2][DEPTH];
  int              init_left [2];
  int              init_addr [2];
  logic            e_we [2], e_zero [2], e_stall [2], e_ill [2];
  logic [4:0]      e_rd [2];
  logic [XLEN-1:0] e_wd [2];

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic int ninit(input int k);
    if (!SWEEP) return 1;
    return (k == 1) ? 16 : 32;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq_n[k] = 0; init_left[k] = ninit(k); init_addr[k] = 0;
      e_we[k] = 1'b0; e_zero[k] = 1'b0; e_stall[k] = 1'b0; e_ill[k] = 1'b0;
      e_rd[k] = '0; e_wd[k] = '0; pv[k] = '0;
      for (int i = 0; i < 4; i++) begin prd[k][i] = '0; pdat[k][i] = '0; end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      src_valid[k] = pv[k];
      for (int i = 0; i < 4; i++) begin
        src_rd[k][5*i +: 5]         = prd[k][i];
        src_data[k][XLEN*i +: XLEN] = pdat[k][i];
      end
    end
  endtask

  task automatic check_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_we", k, 64'(rf_we[k]), 64'd0);
      chk("rst_zero_we", k, 64'(rf_zero_we[k]), 64'd0);
      chk("rst_rd", k, 64'(rf_rd[k]), 64'd0);
      chk("rst_wdata", k, 64'(rf_wdata[k]), 64'd0);
      chk("rst_stall", k, 64'(rd_stall[k]), 64'd0);
      chk("rst_illegal", k, 64'(illegal[k]), 64'd0);
      chk("rst_ready", k, 64'(src_ready[k]), 64'd0);
      chk("rst_busy", k, 64'(busy[k]), 64'd1);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step();
    drive();
    #1;
    for (int k = 0; k < 2; k++) begin
      int g;
      bit full, deq, acc, hz, bsy;
      logic [3:0] rdy;
      logic n_we, n_zero, n_stall, n_ill;
      logic [4:0] n_rd;
      logic [XLEN-1:0] n_wd;
      chk("rf_we", k, 64'(rf_we[k]), 64'(e_we[k]));
      chk("rf_zero_we", k, 64'(rf_zero_we[k]), 64'(e_zero[k]));
      chk("rf_rd", k, 64'(rf_rd[k]), 64'(e_rd[k]));
      chk("rf_wdata", k, 64'(rf_wdata[k]), 64'(e_wd[k]));
      chk("rd_stall", k, 64'(rd_stall[k]), 64'(e_stall[k]));
      chk("illegal", k, 64'(illegal[k]), 64'(e_ill[k]));

      g = -1;
      for (int i = 3; i >= 0; i--) if (pv[k][i]) g = i;
      deq = 1'b0; acc = 1'b0; rdy = '0;
      n_we = 1'b0; n_zero = 1'b0; n_stall = 1'b0; n_ill = 1'b0; n_rd = '0; n_wd = '0;
      if (init_left[k] > 0) begin
        n_we = 1'b1; n_zero = (init_addr[k] == 0); n_rd = 5'(init_addr[k]); n_stall = 1'b1;
      end else begin
        full = (mq_n[k] == int'(DEPTH));
        deq  = (mq_n[k] > 0) && (!rd_req || full);
        acc  = (g >= 0) && (!full || deq);
        if (acc) rdy[g] = 1'b1;
        if (deq) begin
          n_we = 1'b1; n_rd = mq_rd[k][0]; n_wd = mq_dat[k][0]; n_stall = rd_req;
        end
      end

      hz = e_we[k] && ((rs1 != 0 && e_rd[k] == rs1) || (rs2 != 0 && e_rd[k] == rs2));
      for (int j = 0; j < mq_n[k]; j++)
        if ((rs1 != 0 && mq_rd[k][j] == rs1) || (rs2 != 0 && mq_rd[k][j] == rs2)) hz = 1'b1;
      bsy = (init_left[k] > 0) || (mq_n[k] > 0) || e_we[k];
      chk("src_ready", k, 64'(src_ready[k]), 64'(rdy));
      chk("hazard", k, 64'(hazard[k]), 64'(hz));
      chk("busy", k, 64'(busy[k]), 64'(bsy));

      if (deq) begin
        for (int j = 0; j < mq_n[k] - 1; j++) begin
          mq_rd[k][j] = mq_rd[k][j+1]; mq_dat[k][j] = mq_dat[k][j+1];
        end
        mq_n[k]--;
      end
      if (acc) begin
        if (k == 1 && prd[k][g] >= 5'd16) n_ill = 1'b1;
        else if (prd[k][g] != 5'd0) begin
          mq_rd[k][mq_n[k]] = prd[k][g]; mq_dat[k][mq_n[k]] = pdat[k][g]; mq_n[k]++;
        end
        pv[k][g] = 1'b0;
      end
      if (init_left[k] > 0) begin init_left[k]--; init_addr[k]++; end
      e_we[k] = n_we; e_zero[k] = n_zero; e_rd[k] = n_rd; e_wd[k] = n_wd;
      e_stall[k] = n_stall; e_ill[k] = n_ill;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
    for (int k = 0; k < 2; k++) begin pv[k][i] = 1'b1; prd[k][i] = rd; pdat[k][i] = d; end
  endtask

  initial begin
    total = 0; bad = 0;
    rstn = 1'b0; rd_req = 1'b0; rs1 = '0; rs2 = '0;
    model_reset();
    drive();
    repeat (2) @(negedge clk);
    #1 check_reset();
    rstn = 1'b1;
    run(ninit(0) + 3);

    // Single ALU result, then two simultaneous producers.
    load(2, 5'd5, 32'hDEADBEEF);
    run(4);
    load(0, 5'd3, 32'h11);
    load(2, 5'd4, 32'h22);
    run(6);

    // Port busy with reads: buffer fills, then forced drain.
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) load(i, 5'(8 + i), 32'(32'hA0 + i));
    run(5);
    for (int i = 0; i < 4; i++) load(i, 5'(12 + i), 32'(32'hB0 + i));
    run(6);
    rd_req = 1'b0;
    run(6);

    // RAW hazard against a buffered entry, then an x0 result.
    rd_req = 1'b1;
    load(2, 5'd7, 32'h77);
    run(2);
    rs1 = 5'd7;
    run(1);
    rs1 = 5'd0; rs2 = 5'd7;
    run(1);
    rs2 = 5'd0;
    load(0, 5'd0, 32'h99);
    run(2);
    rd_req = 1'b0;
    run(4);

    // Out-of-range destination for RV32E.
    load(1, 5'd20, 32'hABC);
    run(4);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          logic [4:0] r;
          logic [XLEN-1:0] d;
          r = 5'($urandom_range(0, 31));
          d = $urandom;
          for (int k = 0; k < 2; k++)
            if (!pv[k][i]) begin pv[k][i] = 1'b1; prd[k][i] = r; pdat[k][i] = d; end
        end
      end
      rd_req = ($urandom_range(0, 1) == 1);
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      step();
    end

    // Reset in the middle of a burst.
    rs1 = '0; rs2 = '0; rd_req = 1'b1;
    for (int i = 0; i < 4; i++) load(i, 5'(20 + i), 32'(32'hC0 + i));
    run(3);
    #2 rstn = 1'b0;
    model_reset();
    drive();
    #1 check_reset();
    @(negedge clk);
    rstn = 1'b1; rd_req = 1'b0;
    run(ninit(0) + 2);
    load(3, 5'd9, 32'h5A5A5A5A);
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
